regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised integer register file for the rv64i core with NREAD read ports, NWRITE
//  writeback ports, write-to-read bypass, and a per-register busy scoreboard. Decode
//  reserves a destination at issue; writeback clears it. Sits between decode (reads and
//  reservations) and the writeback stage. Unlike the previous file, it resets its contents.
// PARAMETERS
//  XLEN    64  register width in bits
//  NREGS   32  number of architectural registers, including x0; power of two, >=2
//  NREAD   2   number of combinational read ports
//  NWRITE  1   number of writeback ports; higher port index has priority
//  AW      $clog2(NREGS)  address width (derived, not overridden)
// PORTS
//  phi2       in   1             sole clock; all state updates on posedge
//  rst        in   1             asynchronous, active-high reset
//  rd_addr    in   NREAD x AW    read addresses
//  rd_data    out  NREAD x XLEN  read values (bypassed)
//  rd_busy    out  NREAD         1 = the addressed register has a pending write
//  wb_en      in   NWRITE        writeback strobe per port
//  wb_addr    in   NWRITE x AW   writeback destinations
//  wb_data    in   NWRITE x XLEN writeback values
//  rsv_en     in   1             request to reserve rsv_addr as busy
//  rsv_addr   in   AW            destination register to reserve
//  rsv_ok     out  1             reservation accepted this cycle
//  busy_count out  AW+1          number of registers currently marked busy
// BEHAVIOUR
//  Clock and reset: one clock, phi2; asynchronous, active-high reset, rst.
//  Reset (async assert): all registers go to 0, all busy bits to 0, busy_count to 0.
//   - rd_data reads 0 and rd_busy reads 0 for every address while and after reset.
//   - Mid-operation reset discards pending reservations and in-flight writes of that edge.
//  x0: reads 0, rd_busy 0, never written, never reserved. rsv_ok=1 for rsv_addr 0.
//  Write: on posedge phi2, for each port p with wb_en[p] and wb_addr[p]!=0:
//   - file[wb_addr[p]] <= wb_data[p].
//   - The busy bit for that register is cleared.
//   - If several ports target one register, the highest p wins.
//   - A write to a non-busy register is legal. It updates the data; the busy bit stays 0.
//  Read (combinational, zero latency):
//   - If rd_addr==0: rd_data=0.
//   - Else if any wb_en[p] has wb_addr[p]==rd_addr: rd_data=wb_data of the highest such p
//     (bypass), and rd_busy=0.
//   - Else: rd_data=file[rd_addr], and rd_busy=busy[rd_addr].
//  Reserve:
//   - rsv_ok = rsv_en & (rsv_addr==0 | !busy[rsv_addr] | a writeback to rsv_addr this cycle).
//   - On posedge with rsv_ok and rsv_addr!=0, busy[rsv_addr] <= 1.
//   - Reserve and writeback to the same register in one cycle: data is written, busy ends 1
//     (the new reservation wins).
//   - rsv_en with rsv_ok=0 has no effect. Decode must stall and retry.
//  busy_count: registered popcount of the busy bits. It equals the count after each edge.
//   - Range 0..NREGS-1.
//   - A reserve and a clear of different registers in one cycle leave it unchanged.
//  No X propagation: out-of-range addresses do not exist (NREGS = 2**AW).
// TESTING
//  1 Assert rst after random writes -> every rd_data=0, rd_busy=0, busy_count=0.
//    Async: check before the next edge.
//  2 wb x5=64'hDEAD_BEEF_0123_4567, then read x5 next cycle -> value returned, rd_busy=0.
//    Write x0=1 -> x0 still reads 0.
//  3 Reserve x7 -> rsv_ok=1, busy_count=1, rd_busy=1 on x7.
//    Reserve x7 again -> rsv_ok=0, busy_count stays 1.
//  4 With x7 busy: wb x7=42 while reading x7 in the same cycle -> rd_data=42, rd_busy=0.
//    Next cycle: busy_count=0.
//  5 Same cycle: wb x9=3 and reserve x9 (x9 busy) -> rsv_ok=1.
//    Next cycle: x9 reads 3, rd_busy=1, busy_count unchanged.
//  6 NWRITE=2: both ports write x4 (10 on port 0, 20 on port 1) -> bypass shows 20.
//    Next cycle: x4 reads 20.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - rv64i integer register file with write bypass and busy scoreboard
`timescale 1ns/1ps
module regfile_scoreboard #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                        phi2,
    input  logic                        rst,
    input  logic [NREAD-1:0][AW-1:0]    rd_addr,
    output logic [NREAD-1:0][XLEN-1:0]  rd_data,
    output logic [NREAD-1:0]            rd_busy,
    input  logic [NWRITE-1:0]           wb_en,
    input  logic [NWRITE-1:0][AW-1:0]   wb_addr,
    input  logic [NWRITE-1:0][XLEN-1:0] wb_data,
    input  logic                        rsv_en,
    input  logic [AW-1:0]               rsv_addr,
    output logic                        rsv_ok,
    output logic [AW:0]                 busy_count
);

    logic [XLEN-1:0]  regs   [NREGS];
    logic [XLEN-1:0]  wr_val [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic [NREGS-1:0] wr_hit;
    logic [AW:0]      count_nxt;

    // Per-register write decode; later ports overwrite earlier ones so the highest port wins.
    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            wr_val[r] = '0;
        end
        for (int p = 0; p < NWRITE; p++) begin
            if (wb_en[p] && wb_addr[p] != '0) begin
                wr_hit[wb_addr[p]] = 1'b1;
                wr_val[wb_addr[p]] = wb_data[p];
            end
        end
    end

    assign rsv_ok = rsv_en && (rsv_addr == '0 || !busy[rsv_addr] || wr_hit[rsv_addr]);

    // Writeback clears first, then a same-cycle reservation re-marks the register busy.
    always_comb begin
        busy_nxt = busy & ~wr_hit;
        if (rsv_ok && rsv_addr != '0) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        count_nxt = '0;
        for (int r = 0; r < NREGS; r++) begin
            count_nxt = count_nxt + {{AW{1'b0}}, busy_nxt[r]};
        end
    end

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_val[r];
                end
            end
            busy       <= busy_nxt;
            busy_count <= count_nxt;
        end
    end

    // Reads are held at zero during reset so an in-flight writeback cannot leak through the bypass.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            rd_data[i] = regs[rd_addr[i]];
            rd_busy[i] = busy[rd_addr[i]];
            for (int p = 0; p < NWRITE; p++) begin
                if (wb_en[p] && wb_addr[p] == rd_addr[i]) begin
                    rd_data[i] = wb_data[p];
                    rd_busy[i] = 1'b0;
                end
            end
            if (rst || rd_addr[i] == '0) begin
                rd_data[i] = '0;
                rd_busy[i] = 1'b0;
            end
        end
    end

endmodule
